// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: core request/response channels and register-file memory port of the load/store unit
// slave modport (unit side): takes req_*, resp_ready, mem_data_out; drives req_ready, resp_*, mem_address, mem_write_enable, mem_data_in
// master modport (core + memory side): the mirror image
interface mem_access_unit_if #(parameter int DATA_W = 32, parameter int MEM_AW = 5);
  logic req_valid, req_ready, req_we, req_unsigned;
  logic [1:0] req_size;
  logic [31:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic resp_valid, resp_ready, resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic [MEM_AW-1:0] mem_address;
  logic mem_write_enable;
  logic [DATA_W-1:0] mem_data_in, mem_data_out;
  modport slave (
    input req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_write_enable, mem_data_in
  );
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_data_out,
    input req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_write_enable, mem_data_in
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store initiator for a 32x32 register-file memory, one request in flight
// Ports: clk, rst (sync, active-high), bus (mem_access_unit_if.slave: request, response and memory port)
// Optional macro LSU_MISALIGN_CHECK_EN: reject misaligned half/word requests instead of clearing the low address bits
module mem_access_unit #(parameter int DATA_W = 32, parameter int MEM_AW = 5) (
  input logic clk,
  input logic rst,
  mem_access_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;
  state_t state;
  logic ready_q, valid_q, err_q, we_q, st_q, uns_q, bad, unused;
  logic [1:0] size_q, lane_q, lane;
  logic [4:0] sh;
  logic [MEM_AW-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, din_q, shifted, mask, merged, ext;
  assign unused = &{1'b0, bus.req_addr[31:MEM_AW+2]};
  always_comb begin
    lane = bus.req_size == 2'b00 ? bus.req_addr[1:0] : bus.req_size == 2'b01 ? {bus.req_addr[1], 1'b0} : 2'b00;
`ifdef LSU_MISALIGN_CHECK_EN
    bad = &bus.req_size | (bus.req_size == 2'b01 && bus.req_addr[0]) | (bus.req_size == 2'b10 && |bus.req_addr[1:0]);
`else
    bad = &bus.req_size;
`endif
    sh = {lane_q, 3'b000};
    shifted = bus.mem_data_out >> sh;
    mask = (size_q == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    merged = (bus.mem_data_out & ~mask) | ((wdata_q << sh) & mask);
    ext = size_q == 2'b00 ? {{24{~uns_q & shifted[7]}}, shifted[7:0]} :
          size_q == 2'b01 ? {{16{~uns_q & shifted[15]}}, shifted[15:0]} : bus.mem_data_out;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
      addr_q <= '0;
      din_q <= '0;
      we_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          st_q <= bus.req_we;
          size_q <= bus.req_size;
          uns_q <= bus.req_unsigned;
          lane_q <= lane;
          wdata_q <= bus.req_wdata;
          addr_q <= bus.req_addr[MEM_AW+1:2];
          din_q <= bus.req_wdata;
          we_q <= !bad && bus.req_we && bus.req_size == 2'b10;
          ready_q <= 1'b0;
          rdata_q <= '0;
          err_q <= bad;
          valid_q <= bad;
          state <= bad ? RESP : ACCESS;
        end
        ACCESS: if (st_q && size_q != 2'b10) begin
          din_q <= merged;
          we_q <= 1'b1;
          state <= WRITE;
        end else begin
          we_q <= 1'b0;
          rdata_q <= st_q ? '0 : ext;
          valid_q <= 1'b1;
          state <= RESP;
        end
        WRITE: begin
          we_q <= 1'b0;
          valid_q <= 1'b1;
          state <= RESP;
        end
        RESP: if (bus.resp_ready) begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.req_ready = ready_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err = err_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_data_in = din_q;
  // reset must kill a write already registered for this cycle
  assign bus.mem_write_enable = we_q & ~rst;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit with a behavioural 32x32 register-file memory
module tb_mem_access_unit;
  typedef struct packed {
    logic [31:0] rdata;
    logic err;
    logic [7:0] lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  logic [31:0] mem [32];
  exp_t q[$];
  mem_access_unit_if bus();
  mem_access_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.mem_write_enable) begin
    mem[bus.mem_address] <= bus.mem_data_in;
    wr_cnt <= wr_cnt + 1;
  end
  assign bus.mem_data_out = mem[bus.mem_address];
  task automatic send(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] erd, input logic eerr, input logic [7:0] elat);
    exp_t x;
    x = {erd, eerr, elat};
    q.push_back(x);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_size = size;
    bus.req_unsigned = uns;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask
  task automatic wait_resp(input bit accept, output logic [31:0] rd, output logic er, output logic [7:0] lat);
    lat = 8'd1;
    while (!bus.resp_valid && lat < 8'd40) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.resp_valid) lat = 8'hFF;
    rd = bus.resp_rdata;
    er = bus.resp_err;
    if (accept && bus.resp_valid) begin
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 7;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
    if (bus.resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_resp_rdata got=%h exp=0", bus.resp_rdata); end
    if (bus.resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp_err got=%b exp=0", bus.resp_err); end
    if (bus.mem_address !== 5'd0) begin failures++; $display("FAIL reset_mem_address got=%0d exp=0", bus.mem_address); end
    if (bus.mem_data_in !== 32'h0) begin failures++; $display("FAIL reset_mem_data_in got=%h exp=0", bus.mem_data_in); end
    if (bus.mem_write_enable !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", bus.mem_write_enable); end
    rst = 1'b0;
  endtask
  task automatic test_word;
    logic [31:0] a[4] = '{32'h0C, 32'h00, 32'h14, 32'h1C};
    logic [31:0] d[4] = '{32'hDEADBEEF, 32'h0BADF00D, 32'h11223344, 32'h80FF7F01};
    logic [31:0] rd;
    logic er;
    logic [7:0] lat;
    exp_t x;
    int w0;
    for (int i = 0; i < 4; i++) begin
      w0 = wr_cnt;
      send(1'b1, 2'b10, 1'b0, a[i], d[i], 32'h0, 1'b0, 8'd2);
      checks += 2;
      if (bus.mem_address !== a[i][6:2]) begin failures++; $display("FAIL word_store_addr got=%0d exp=%0d", bus.mem_address, a[i][6:2]); end
      if (bus.mem_write_enable !== 1'b1) begin failures++; $display("FAIL word_store_we got=%b exp=1", bus.mem_write_enable); end
      wait_resp(1'b1, rd, er, lat);
      x = q.pop_front();
      checks += 3;
      if ({rd, er, lat} !== x) begin failures++; $display("FAIL word_store_resp got=%h/%b/%0d exp=%h/%b/%0d", rd, er, lat, x.rdata, x.err, x.lat); end
      if (wr_cnt - w0 != 1) begin failures++; $display("FAIL word_store_we_cycles got=%0d exp=1", wr_cnt - w0); end
      if (mem[a[i][6:2]] !== d[i]) begin failures++; $display("FAIL word_store_mem got=%h exp=%h", mem[a[i][6:2]], d[i]); end
    end
    send(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'hDEADBEEF, 1'b0, 8'd2);
    wait_resp(1'b1, rd, er, lat);
    x = q.pop_front();
    checks++;
    if ({rd, er, lat} !== x) begin failures++; $display("FAIL word_load got=%h/%b/%0d exp=%h/%b/%0d", rd, er, lat, x.rdata, x.err, x.lat); end
  endtask
  task automatic test_subword_store;
    logic [31:0] a[4] = '{32'h16, 32'h14, 32'h16, 32'h14};
    logic [1:0] s[4] = '{2'b00, 2'b10, 2'b01, 2'b10};
    logic [31:0] d[4] = '{32'h000000AA, 32'h0, 32'hFFFFCAFE, 32'h0};
    logic st[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] er_d[4] = '{32'h0, 32'h11AA3344, 32'h0, 32'hCAFE3344};
    logic [7:0] el[4] = '{8'd3, 8'd2, 8'd3, 8'd2};
    logic [31:0] rd;
    logic er;
    logic [7:0] lat;
    exp_t x;
    int w0;
    for (int i = 0; i < 4; i++) begin
      w0 = wr_cnt;
      send(st[i], s[i], 1'b0, a[i], d[i], er_d[i], 1'b0, el[i]);
      wait_resp(1'b1, rd, er, lat);
      x = q.pop_front();
      checks += 2;
      if ({rd, er, lat} !== x) begin failures++; $display("FAIL subword_resp[%0d] got=%h/%b/%0d exp=%h/%b/%0d", i, rd, er, lat, x.rdata, x.err, x.lat); end
      if (wr_cnt - w0 != (st[i] ? 1 : 0)) begin failures++; $display("FAIL subword_writes[%0d] got=%0d exp=%0d", i, wr_cnt - w0, st[i] ? 1 : 0); end
    end
  endtask
  task automatic test_load_ext;
    logic [31:0] a[6] = '{32'h1D, 32'h1E, 32'h1E, 32'h1F, 32'h1C, 32'h1C};
    logic [1:0] s[6] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01};
    logic u[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] e[6] = '{32'h0000007F, 32'hFFFF80FF, 32'h000080FF, 32'hFFFFFF80, 32'h00000001, 32'h00007F01};
    logic [31:0] rd;
    logic er;
    logic [7:0] lat;
    exp_t x;
    for (int i = 0; i < 6; i++) begin
      send(1'b0, s[i], u[i], a[i], 32'hFFFFFFFF, e[i], 1'b0, 8'd2);
      wait_resp(1'b1, rd, er, lat);
      x = q.pop_front();
      checks++;
      if ({rd, er, lat} !== x) begin failures++; $display("FAIL load_ext[%0d] got=%h/%b/%0d exp=%h/%b/%0d", i, rd, er, lat, x.rdata, x.err, x.lat); end
    end
  endtask
  task automatic test_backpressure;
    logic [31:0] rd;
    logic er;
    logic [7:0] lat;
    exp_t x;
    int w0;
    send(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'hCAFE3344, 1'b0, 8'd2);
    wait_resp(1'b0, rd, er, lat);
    x = q.pop_front();
    w0 = wr_cnt;
    checks++;
    if ({rd, er, lat} !== x) begin failures++; $display("FAIL bp_resp got=%h/%b/%0d exp=%h/%b/%0d", rd, er, lat, x.rdata, x.err, x.lat); end
    for (int i = 0; i < 5; i++) begin
      checks += 2;
      if ({bus.resp_valid, bus.resp_rdata, bus.resp_err} !== {1'b1, x.rdata, x.err})
        begin failures++; $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=1/%h/%b", i, bus.resp_valid, bus.resp_rdata, bus.resp_err, x.rdata, x.err); end
      if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL bp_req_ready[%0d] got=%b exp=0", i, bus.req_ready); end
      if (i == 1) begin
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_size = 2'b10;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h12345678;
      end
      if (i == 2) bus.req_valid = 1'b0;
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    checks += 4;
    if (wr_cnt != w0) begin failures++; $display("FAIL bp_no_write got=%0d exp=0", wr_cnt - w0); end
    if (mem[0] !== 32'h0BADF00D) begin failures++; $display("FAIL bp_mem0 got=%h exp=0badf00d", mem[0]); end
    if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", bus.resp_valid); end
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", bus.req_ready); end
  endtask
  task automatic test_reset_abort;
    int w0;
    w0 = wr_cnt;
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h1C;
    bus.req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_write_enable !== 1'b1) begin failures++; $display("FAIL abort_write_phase got=%b exp=1", bus.mem_write_enable); end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_write_enable !== 1'b0) begin failures++; $display("FAIL abort_we_gated got=%b exp=0", bus.mem_write_enable); end
    @(negedge clk);
    rst = 1'b0;
    checks += 4;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL abort_req_ready got=%b exp=1", bus.req_ready); end
    if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL abort_resp_valid got=%b exp=0", bus.resp_valid); end
    if (mem[7] !== 32'h80FF7F01) begin failures++; $display("FAIL abort_mem got=%h exp=80ff7f01", mem[7]); end
    if (wr_cnt != w0) begin failures++; $display("FAIL abort_writes got=%0d exp=0", wr_cnt - w0); end
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL abort_no_resp got=%b exp=0", bus.resp_valid); end
  endtask
  task automatic test_error;
    logic [31:0] rd;
    logic er;
    logic [7:0] lat;
    exp_t x;
    int w0;
    for (int i = 0; i < 2; i++) begin
      w0 = wr_cnt;
      send(i == 0, 2'b11, 1'b0, 32'h08, 32'hFFFFFFFF, 32'h0, 1'b1, 8'd1);
      wait_resp(1'b1, rd, er, lat);
      x = q.pop_front();
      checks += 2;
      if ({rd, er, lat} !== x) begin failures++; $display("FAIL size11[%0d] got=%h/%b/%0d exp=%h/%b/%0d", i, rd, er, lat, x.rdata, x.err, x.lat); end
      if (wr_cnt != w0) begin failures++; $display("FAIL size11_no_write[%0d] got=%0d exp=0", i, wr_cnt - w0); end
    end
  endtask
  task automatic test_misalign;
    logic [31:0] rd;
    logic er;
    logic [7:0] lat;
    exp_t x;
`ifdef LSU_MISALIGN_CHECK_EN
    send(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 32'h0, 1'b1, 8'd1);
`else
    send(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 32'h0BADF00D, 1'b0, 8'd2);
`endif
    wait_resp(1'b1, rd, er, lat);
    x = q.pop_front();
    checks++;
    if ({rd, er, lat} !== x) begin failures++; $display("FAIL misalign_word got=%h/%b/%0d exp=%h/%b/%0d", rd, er, lat, x.rdata, x.err, x.lat); end
`ifdef LSU_MISALIGN_CHECK_EN
    send(1'b0, 2'b01, 1'b0, 32'h1F, 32'h0, 32'h0, 1'b1, 8'd1);
`else
    send(1'b0, 2'b01, 1'b0, 32'h1F, 32'h0, 32'hFFFF80FF, 1'b0, 8'd2);
`endif
    wait_resp(1'b1, rd, er, lat);
    x = q.pop_front();
    checks++;
    if ({rd, er, lat} !== x) begin failures++; $display("FAIL misalign_half got=%h/%b/%0d exp=%h/%b/%0d", rd, er, lat, x.rdata, x.err, x.lat); end
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_word();
    test_subword_store();
    test_load_ext();
    test_backpressure();
    test_reset_abort();
    test_error();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
